// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one MFA/MFC memory port between instruction fetch (requester 0)
// and data load/store (requester 1), sequencing a four-phase handshake with timeout abort.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int DATA_PRIORITY  = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              REQ0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic              REQ1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA1,
  input  logic              RW1,
  input  logic              WB1,
  output logic              ACK0,
  output logic              ACK1,
  output logic [DATA_W-1:0] RDATA,
  output logic              TIMEOUT,
  output logic              BUSY,
  output logic              MFA,
  output logic              READ_WRITE,
  output logic              WORD_BYTE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MFC
);
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_grant_q, owner_q;
  logic              ack0_q, ack1_q, timeout_q, busy_q, mfa_q, rw_q, wb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  logic              grant_d, pick_d, rw_d, wb_d;
  logic [ADDR_W-1:0] addr_sel, addr_d;
  logic [DATA_W-1:0] wdata_d, rdata_d;

  always_comb begin
    grant_d = !MFC && (REQ0 || REQ1);
    if (REQ0 && REQ1) pick_d = (DATA_PRIORITY != 0) ? 1'b1 : ~last_grant_q;
    else              pick_d = REQ1;
    addr_sel = pick_d ? ADDR1 : ADDR0;
    // Fetch is always a word read; only the data requester can write or go byte-wide.
    rw_d     = pick_d ? RW1 : 1'b1;
    wb_d     = pick_d ? WB1 : 1'b1;
    wdata_d  = (pick_d && !RW1) ? WDATA1 : '0;
    addr_d   = wb_d ? {addr_sel[ADDR_W-1:2], 2'b00} : addr_sel;
    rdata_d  = wb_q ? MEM_RDATA : DATA_W'(MEM_RDATA[7:0]);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      mfa_q        <= 1'b0;
      rw_q         <= 1'b0;
      wb_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_d) begin
            state_q      <= S_WAIT;
            busy_q       <= 1'b1;
            mfa_q        <= 1'b1;
            owner_q      <= pick_d;
            last_grant_q <= pick_d;
            cnt_q        <= '0;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            wb_q         <= wb_d;
            wdata_q      <= wdata_d;
          end
        end
        S_WAIT: begin
          if (MFC) begin
            state_q <= S_RELEASE;
            mfa_q   <= 1'b0;
            ack0_q  <= ~owner_q;
            ack1_q  <= owner_q;
            if (rw_q) rdata_q <= rdata_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= S_RELEASE;
            mfa_q     <= 1'b0;
            ack0_q    <= ~owner_q;
            ack1_q    <= owner_q;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (!MFC) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ACK0       = ack0_q;
  assign ACK1       = ack1_q;
  assign TIMEOUT    = timeout_q;
  assign BUSY       = busy_q;
  assign MFA        = mfa_q;
  assign READ_WRITE = rw_q;
  assign WORD_BYTE  = wb_q;
  assign MEM_ADDR   = addr_q;
  assign MEM_WDATA  = wdata_q;
  assign RDATA      = rdata_q;

endmodule
